rv_soc_apb_dec_mux: RTL and testbench
=====================================

# rv_soc_apb_dec_mux

Parametrised APB decoder/multiplexer for the SoC peripheral subsystem: splits one APB master port into `SLAVES` slave ports using per-slave base/mask compare. It replaces combinational decode with a registered decode stage. It adds three behaviours:
- an error response for unmapped or privilege-violating accesses;
- a per-transfer timeout that terminates hung slaves;
- a captured error record for software/debug.

It sits between the AHB-to-APB bridge and the PLIC/user APB buses.

## Interface
Clock `PCLK`; reset `PRESET` is asynchronous and active-high.

Parameters:
- `PADDR_SIZE`, 12: address width.
- `PDATA_SIZE`, 32: data width (8/16/32/64).
- `SLAVES`, 4: number of slave ports, 1..32.
- `TIMEOUT`, 256: max slave wait cycles; 0 disables the timeout.
- `PRIV_MASK`, 0: `SLAVES`-bit mask. Bit n set means slave n requires `PPROT[0]=1` (privileged).

Ports:
- `PCLK` in 1: clock.
- `PRESET` in 1: async active-high reset.
- `PSEL`, `PENABLE`, `PWRITE` in 1: master APB control.
- `PPROT` in 3: protection.
- `PADDR` in `PADDR_SIZE`: address.
- `PRDATA` out `PDATA_SIZE`; `PREADY` out 1; `PSLVERR` out 1: master response.
- `slv_addr` in `PADDR_SIZE` [SLAVES]: base address per slave.
- `slv_mask` in `PADDR_SIZE` [SLAVES]: compare mask per slave (1 = compare bit).
- `SLV_PSEL` out 1 [SLAVES]: per-slave select.
- `SLV_PENABLE` out 1: regenerated enable, common to all slaves.
- `SLV_PRDATA` in `PDATA_SIZE` [SLAVES]; `SLV_PREADY` in 1 [SLAVES]; `SLV_PSLVERR` in 1 [SLAVES]: slave responses.
- `err_valid_o` out 1: one-cycle pulse on any error termination.
- `err_code_o` out 2: error code, `01` unmapped, `10` privilege, `11` timeout. Held until the next error.
- `err_addr_o` out `PADDR_SIZE`: address of the last errored transfer. Held until the next error.

## Operation
- Decode: slave n matches when `(PADDR & slv_mask[n]) == (slv_addr[n] & slv_mask[n])`. The lowest matching index wins.
  - No match gives error code `01`.
  - A match with `PRIV_MASK[n]=1` and `PPROT[0]=0` gives error code `10`.
- Decode is evaluated on the master setup cycle (`PSEL & ~PENABLE`). Its result (index plus error code) is registered on that edge.
- The FSM has four states: IDLE, SSETUP, SACCESS, ERR.
  - IDLE: on master setup with a valid decode, go to SSETUP; with an error decode, go to ERR.
  - SSETUP: `SLV_PSEL[idx]=1`, `SLV_PENABLE=0`, `PREADY=0`. Next state is SACCESS.
  - SACCESS: `SLV_PSEL[idx]=1`, `SLV_PENABLE=1`. `PREADY`, `PRDATA` and `PSLVERR` are forwarded combinationally from slave idx. On `SLV_PREADY[idx]=1`, go to IDLE.
  - ERR: `PREADY=1`, `PSLVERR=1`, `PRDATA=0` for exactly one cycle, then IDLE. No `SLV_PSEL` is asserted.
- Timeout (`TIMEOUT>0`): a wait counter clears on entry to SACCESS and increments each SACCESS cycle with `SLV_PREADY[idx]=0`.
  - When the count equals `TIMEOUT-1` and the slave is still not ready, the master gets `PREADY=1`, `PSLVERR=1`, `PRDATA=0` in that cycle, and error code `11` is recorded.
  - `SLV_PSEL` and `SLV_PENABLE` drop the following cycle.
  - If slave ready arrives in the same cycle as the timeout, the slave response wins and no error is recorded.
- `PWRITE`, `PWDATA`, `PSTRB` and `PADDR` are not muxed. The master holds them stable through the extended access phase.
- Outside SSETUP/SACCESS, all `SLV_PSEL` = 0. `PRDATA`=0, `PREADY`=0, `PSLVERR`=0 in IDLE.
- Error record: `err_code_o` and `err_addr_o` are written, and `err_valid_o` pulses, in the cycle the master is terminated with an error from ERR or from timeout. Slave-originated `PSLVERR` is not recorded.
- Master `PSEL` deasserting mid-transfer is a protocol violation. The FSM completes the current slave transfer regardless.

## Timing
- Reset (async assert, sync release): FSM to IDLE; all `SLV_PSEL`=0, `SLV_PENABLE`=0, `PREADY`=0, `PSLVERR`=0, `PRDATA`=0, counter=0, `err_valid_o`=0, `err_code_o`=`00`, `err_addr_o`=0.
- Reset asserted mid-transfer aborts immediately. The slave sees `PSEL` drop asynchronously.
- Latency adds one wait state per transfer.
  - Zero-wait slave: master access phase is 2 cycles (SSETUP, SACCESS).
  - Slave with k waits: 2+k cycles.
  - Unmapped/privilege error: master access phase is 1 cycle (ERR).
- Back-to-back: master setup may occur in the cycle after `PREADY=1`. IDLE accepts it without a bubble.
- Counter width is `$clog2(TIMEOUT+1)` and saturates; it never wraps.

## Structure
- Package `rv_soc_apb_pkg`:
  - `apb_dec_state_t` enum (IDLE, SSETUP, SACCESS, ERR);
  - `apb_err_code_t` (`NONE=2'b00`, `UNMAPPED=2'b01`, `PRIV=2'b10`, `TIMEOUT=2'b11`).
- Sub-module `rv_soc_apb_tmo_cnt`: parametrised saturating wait counter with clear, increment and expiry compare. It is tied off when `TIMEOUT=0`.
- Decode is a combinational function in the same file. The slave response mux is indexed by the registered idx.

## Test plan
- `SLAVES=4`, slave 2 at 0x200 mask 0xF00, zero-wait; read 0x204 -> `SLV_PSEL[2]` for 2 cycles, `SLV_PENABLE` in cycle 2 only, master `PREADY` in cycle 2, `PRDATA`=slave data.
- Access to 0xF00 (unmapped) -> 1-cycle `PREADY=1`, `PSLVERR=1`, `PRDATA=0`, no `SLV_PSEL`, `err_code_o=01`, `err_addr_o=0xF00`, `err_valid_o` 1-cycle pulse.
- `PRIV_MASK=4'b0010`, access to slave 1 with `PPROT=3'b000` -> error code `10`; the same access with `PPROT=3'b001` completes normally.
- `TIMEOUT=8`, slave never ready -> `PREADY=1`, `PSLVERR=1` on the 8th SACCESS cycle, `SLV_PSEL` low the next cycle, code `11`. A slave ready on exactly that cycle -> normal completion, no error.
- `PRESET` asserted during SACCESS -> all outputs 0 immediately; the next transfer after release completes normally; two back-to-back transfers with no idle cycle both complete with the correct slave selected.

Source files
------------

// File: rtl/rv_soc_apb_pkg.sv
// Shared types for the APB decoder/multiplexer: FSM state encoding and the
// error codes reported to software through the error record.
package rv_soc_apb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SSETUP  = 2'b01,
        SACCESS = 2'b10,
        ERR     = 2'b11
    } apb_dec_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_PRIV     = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } apb_err_code_t;

endpackage

// File: rtl/rv_soc_apb_tmo_cnt.sv
// Saturating slave wait counter; expire flags the last permitted wait cycle.
// A LIMIT of 0 removes the counter entirely and expire never asserts.
module rv_soc_apb_tmo_cnt #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    generate
        if (LIMIT > 0) begin : g_cnt
            logic [CW-1:0] cnt;

            // Holds at LIMIT rather than wrapping so a stale count can never re-expire.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (inc && (cnt != CW'(LIMIT))) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign expire = (cnt == CW'(LIMIT - 1));
        end else begin : g_off
            logic unused_tie;
            assign unused_tie = ^{clk, rst, clr, inc};
            assign expire     = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/rv_soc_apb_dec_mux.sv
// APB decoder/multiplexer with a registered decode stage, error termination for
// unmapped/privileged accesses, a slave wait timeout and a captured error record.
module rv_soc_apb_dec_mux
    import rv_soc_apb_pkg::*;
#(
    parameter int                PADDR_SIZE = 12,
    parameter int                PDATA_SIZE = 32,
    parameter int                SLAVES     = 4,
    parameter int                TIMEOUT    = 256,
    parameter logic [SLAVES-1:0] PRIV_MASK  = '0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [2:0]            PPROT,
    input  logic [PADDR_SIZE-1:0] PADDR,
    output logic [PDATA_SIZE-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [PADDR_SIZE-1:0] slv_addr    [SLAVES],
    input  logic [PADDR_SIZE-1:0] slv_mask    [SLAVES],
    output logic                  SLV_PSEL    [SLAVES],
    output logic                  SLV_PENABLE,
    input  logic [PDATA_SIZE-1:0] SLV_PRDATA  [SLAVES],
    input  logic                  SLV_PREADY  [SLAVES],
    input  logic                  SLV_PSLVERR [SLAVES],
    output logic                  err_valid_o,
    output logic [1:0]            err_code_o,
    output logic [PADDR_SIZE-1:0] err_addr_o
);

    localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        apb_err_code_t    code;
    } dec_t;

    // Lowest matching index wins, hence the descending scan.
    function automatic dec_t decode(
        input logic [PADDR_SIZE-1:0] addr,
        input logic                  priv,
        input logic [PADDR_SIZE-1:0] base [SLAVES],
        input logic [PADDR_SIZE-1:0] mask [SLAVES]
    );
        dec_t d;
        logic hit;
        d.idx  = '0;
        d.code = ERR_NONE;
        hit    = 1'b0;
        for (int n = SLAVES - 1; n >= 0; n--) begin
            if ((addr & mask[n]) == (base[n] & mask[n])) begin
                hit   = 1'b1;
                d.idx = IDX_W'(n);
            end
        end
        if (!hit) begin
            d.code = ERR_UNMAPPED;
        end else if (PRIV_MASK[d.idx] && !priv) begin
            d.code = ERR_PRIV;
        end
        return d;
    endfunction

    apb_dec_state_t        state, state_d;
    dec_t                  dec;
    logic                  setup;
    logic [IDX_W-1:0]      idx_q;
    apb_err_code_t         code_q;
    logic [PADDR_SIZE-1:0] addr_q;
    apb_err_code_t         rec_code;
    logic [PADDR_SIZE-1:0] rec_addr;
    logic                  slv_rdy;
    logic                  tmo_inc;
    logic                  tmo_expire;
    logic                  tmo_fire;
    apb_err_code_t         cur_code;
    logic                  unused_sig;

    assign unused_sig = ^{PWRITE, PPROT[2:1]};
    assign setup      = PSEL & ~PENABLE;
    assign dec        = decode(PADDR, PPROT[0], slv_addr, slv_mask);
    assign slv_rdy    = SLV_PREADY[idx_q];
    assign tmo_inc    = (state == SACCESS) & ~slv_rdy;

    rv_soc_apb_tmo_cnt #(
        .LIMIT (TIMEOUT)
    ) u_tmo_cnt (
        .clk    (PCLK),
        .rst    (PRESET),
        .clr    (state == SSETUP),
        .inc    (tmo_inc),
        .expire (tmo_expire)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            idx_q    <= '0;
            code_q   <= ERR_NONE;
            addr_q   <= '0;
            rec_code <= ERR_NONE;
            rec_addr <= '0;
        end else begin
            state <= state_d;
            if ((state == IDLE) && setup) begin
                idx_q  <= dec.idx;
                code_q <= dec.code;
                addr_q <= PADDR;
            end
            if (err_valid_o) begin
                rec_code <= cur_code;
                rec_addr <= addr_q;
            end
        end
    end

    always_comb begin
        state_d     = state;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        PRDATA      = '0;
        SLV_PENABLE = 1'b0;
        tmo_fire    = 1'b0;
        for (int n = 0; n < SLAVES; n++) begin
            SLV_PSEL[n] = 1'b0;
        end
        case (state)
            IDLE: begin
                if (setup) begin
                    state_d = (dec.code == ERR_NONE) ? SSETUP : ERR;
                end
            end
            SSETUP: begin
                SLV_PSEL[idx_q] = 1'b1;
                state_d         = SACCESS;
            end
            SACCESS: begin
                SLV_PSEL[idx_q] = 1'b1;
                SLV_PENABLE     = 1'b1;
                // A ready slave on the expiry cycle takes precedence over the timeout.
                tmo_fire        = ~slv_rdy & tmo_expire;
                PREADY          = slv_rdy | tmo_fire;
                PSLVERR         = tmo_fire | SLV_PSLVERR[idx_q];
                PRDATA          = tmo_fire ? '0 : SLV_PRDATA[idx_q];
                if (slv_rdy || tmo_fire) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The record shows the new error during the terminating cycle and holds it afterwards.
    assign err_valid_o = (state == ERR) | tmo_fire;
    assign cur_code    = (state == ERR) ? code_q : ERR_TIMEOUT;
    assign err_code_o  = err_valid_o ? cur_code : rec_code;
    assign err_addr_o  = err_valid_o ? addr_q : rec_addr;

endmodule

// File: tb/tb_rv_soc_apb_dec_mux.sv
// Directed bench for rv_soc_apb_dec_mux: a vector table of single transfers
// plus hand-written overlap-priority and mid-transfer reset sequences.
module tb_rv_soc_apb_dec_mux;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int NV = 11;

    logic          clk = 1'b0;
    logic          PRESET = 1'b1;
    logic          PSEL, PENABLE, PWRITE;
    logic [2:0]    PPROT;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;
    logic [AW-1:0] slv_addr    [NS];
    logic [AW-1:0] slv_mask    [NS];
    logic          slv_psel    [NS];
    logic          slv_penable;
    logic [DW-1:0] slv_prdata  [NS];
    logic          slv_pready  [NS];
    logic          slv_pslverr [NS];
    logic          err_valid;
    logic [1:0]    err_code;
    logic [AW-1:0] err_addr;

    int            checks = 0;
    int            errors = 0;
    logic [1:0]    last_code;
    logic [AW-1:0] last_addr;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    prot;
        int            rdy_at;
        logic          slv_err;
        logic [NS-1:0] exp_sel;
        int            exp_cyc;
        logic [DW-1:0] exp_rdata;
        logic          exp_slverr;
        logic          exp_errv;
        logic [1:0]    exp_code;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    rv_soc_apb_dec_mux #(
        .PADDR_SIZE (AW),
        .PDATA_SIZE (DW),
        .SLAVES     (NS),
        .TIMEOUT    (8),
        .PRIV_MASK  (4'b0010)
    ) dut (
        .PCLK        (clk),
        .PRESET      (PRESET),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PPROT       (PPROT),
        .PADDR       (PADDR),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .slv_addr    (slv_addr),
        .slv_mask    (slv_mask),
        .SLV_PSEL    (slv_psel),
        .SLV_PENABLE (slv_penable),
        .SLV_PRDATA  (slv_prdata),
        .SLV_PREADY  (slv_pready),
        .SLV_PSLVERR (slv_pslverr),
        .err_valid_o (err_valid),
        .err_code_o  (err_code),
        .err_addr_o  (err_addr)
    );

    function automatic logic [NS-1:0] sel_vec();
        logic [NS-1:0] s;
        for (int n = 0; n < NS; n++) s[n] = slv_psel[n];
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ready(input logic r);
        for (int n = 0; n < NS; n++) slv_pready[n] = r;
    endtask

    // Entered and left just after a rising edge; setup is driven immediately,
    // so consecutive calls produce back-to-back transfers.
    task automatic run_vec(input string name, input vec_t v);
        int cyc;
        bit done;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PADDR   = v.addr;
        PPROT   = v.prot;
        for (int n = 0; n < NS; n++) slv_pslverr[n] = v.slv_err;
        @(negedge clk);
        chk({name, "_setup_sel"}, 32'(sel_vec()), 32'h0);
        chk({name, "_setup_ready"}, 32'(PREADY), 32'h0);
        @(posedge clk);
        #1;
        PENABLE = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            set_ready((v.rdy_at == 0) || (cyc + 1 >= v.rdy_at));
            @(negedge clk);
            cyc++;
            chk($sformatf("%s_c%0d_sel", name, cyc), 32'(sel_vec()), 32'(v.exp_sel));
            chk($sformatf("%s_c%0d_penable", name, cyc), 32'(slv_penable),
                32'((v.exp_sel != 0) && (cyc > 1)));
            if (PREADY) begin
                done = 1'b1;
                chk({name, "_rdata"}, PRDATA, v.exp_rdata);
                chk({name, "_slverr"}, 32'(PSLVERR), 32'(v.exp_slverr));
                chk({name, "_err_valid"}, 32'(err_valid), 32'(v.exp_errv));
                if (v.exp_errv) begin
                    last_code = v.exp_code;
                    last_addr = v.addr;
                end
                chk({name, "_err_code"}, 32'(err_code), 32'(last_code));
                chk({name, "_err_addr"}, 32'(err_addr), 32'(last_addr));
            end else begin
                chk($sformatf("%s_c%0d_err_valid", name, cyc), 32'(err_valid), 32'h0);
            end
            @(posedge clk);
            #1;
        end
        chk({name, "_cycles"}, 32'(cyc), 32'(v.exp_cyc));
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        set_ready(1'b1);
        for (int n = 0; n < NS; n++) slv_pslverr[n] = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_sel"}, 32'(sel_vec()), 32'h0);
        chk({name, "_penable"}, 32'(slv_penable), 32'h0);
        chk({name, "_pready"}, 32'(PREADY), 32'h0);
        chk({name, "_pslverr"}, 32'(PSLVERR), 32'h0);
        chk({name, "_prdata"}, PRDATA, 32'h0);
        chk({name, "_err_valid"}, 32'(err_valid), 32'h0);
        chk({name, "_err_code"}, 32'(err_code), 32'h0);
        chk({name, "_err_addr"}, 32'(err_addr), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        //           addr     prot    rdy err  sel      cyc rdata          serr  ev    code
        vecs[0]  = '{12'h204, 3'b000, 0,  1'b0, 4'b0100, 2, 32'hA000_0002, 1'b0, 1'b0, 2'b00};
        vecs[1]  = '{12'hF00, 3'b000, 0,  1'b0, 4'b0000, 1, 32'h0,         1'b1, 1'b1, 2'b01};
        vecs[2]  = '{12'h110, 3'b000, 0,  1'b0, 4'b0000, 1, 32'h0,         1'b1, 1'b1, 2'b10};
        vecs[3]  = '{12'h110, 3'b001, 0,  1'b0, 4'b0010, 2, 32'hA000_0001, 1'b0, 1'b0, 2'b00};
        vecs[4]  = '{12'h3FC, 3'b000, 0,  1'b0, 4'b1000, 2, 32'hA000_0003, 1'b0, 1'b0, 2'b00};
        vecs[5]  = '{12'h000, 3'b000, 0,  1'b0, 4'b0001, 2, 32'hA000_0000, 1'b0, 1'b0, 2'b00};
        vecs[6]  = '{12'h2F0, 3'b000, 4,  1'b0, 4'b0100, 4, 32'hA000_0002, 1'b0, 1'b0, 2'b00};
        vecs[7]  = '{12'h004, 3'b000, 99, 1'b0, 4'b0001, 9, 32'h0,         1'b1, 1'b1, 2'b11};
        vecs[8]  = '{12'h304, 3'b000, 9,  1'b0, 4'b1000, 9, 32'hA000_0003, 1'b0, 1'b0, 2'b00};
        vecs[9]  = '{12'h100, 3'b111, 0,  1'b0, 4'b0010, 2, 32'hA000_0001, 1'b0, 1'b0, 2'b00};
        vecs[10] = '{12'h208, 3'b000, 0,  1'b1, 4'b0100, 2, 32'hA000_0002, 1'b1, 1'b0, 2'b00};

        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PPROT   = 3'b000;
        PADDR   = '0;
        for (int n = 0; n < NS; n++) begin
            slv_addr[n]    = AW'(n * 256);
            slv_mask[n]    = 12'hF00;
            slv_prdata[n]  = 32'hA000_0000 + 32'(n);
            slv_pready[n]  = 1'b1;
            slv_pslverr[n] = 1'b0;
        end
        last_code = 2'b00;
        last_addr = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        PRESET = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Slave 3 made to match everything: lowest matching index must win.
        slv_mask[3] = 12'h000;
        v = '{12'hF00, 3'b000, 0, 1'b0, 4'b1000, 2, 32'hA000_0003, 1'b0, 1'b0, 2'b00};
        run_vec("ovl_f00", v);
        v = '{12'h204, 3'b000, 0, 1'b0, 4'b0100, 2, 32'hA000_0002, 1'b0, 1'b0, 2'b00};
        run_vec("ovl_204", v);
        slv_mask[3] = 12'hF00;

        // Reset in the middle of a stalled SACCESS.
        @(posedge clk);
        #1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PADDR   = 12'h208;
        set_ready(1'b0);
        @(posedge clk);
        #1;
        PENABLE = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mid_pre_sel", 32'(sel_vec()), 32'h4);
        chk("rst_mid_pre_rdata", PRDATA, 32'hA000_0002);
        PRESET = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(posedge clk);
        #1;
        PRESET  = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        set_ready(1'b1);
        last_code = 2'b00;
        last_addr = '0;
        @(posedge clk);
        #1;
        v = '{12'h20C, 3'b000, 0, 1'b0, 4'b0100, 2, 32'hA000_0002, 1'b0, 1'b0, 2'b00};
        run_vec("post_rst", v);
        v = '{12'h1F0, 3'b001, 0, 1'b0, 4'b0010, 2, 32'hA000_0001, 1'b0, 1'b0, 2'b00};
        run_vec("post_rst_b2b", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
